// File: rtl/aes_pkg.sv
// Shared AES tables, round-count derivation and FSM state type used by the
// iterative encryptor and its combinational round stage.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aesState_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic int numRounds(input int keyL);
        return (keyL == 256) ? 14 : 10;
    endfunction

    // Out-of-range indices only occur while the datapath is idle, so they map to zero.
    function automatic logic [7:0] rconAt(input logic [3:0] idx);
        return (idx < 4'd10) ? RCON[idx] : 8'h00;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Byte i of the block sits at bits [127-8i -: 8], column-major as in FIPS-197.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] roundKey_i,
    input  logic         finalRound_i,
    output logic [127:0] state_o
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        state_o = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = SBOX[state_i[127-8*i -: 8]];
        end
        // Row r of column c takes the byte from column (c + r) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        for (int i = 0; i < 16; i++) begin
            state_o[127-8*i -: 8] = (finalRound_i ? sr[i] : mc[i]) ^ roundKey_i[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_iter_encrypt.sv
// Iterative AES encryptor: one round per clock with the key schedule expanded
// on the fly from a KEY_L-bit window register.
module aes_iter_encrypt
    import aes_pkg::*;
#(
    parameter int KEY_L  = 128,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [KEY_L-1:0]  cipher_key,
    input  logic [DATA_W-1:0] plain_text,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] cipher_text,
    output logic              busy
);

    if (KEY_L != 128 && KEY_L != 256) begin : gBadKeyL
        $error("aes_iter_encrypt: KEY_L must be 128 or 256");
    end
    if (DATA_W != 128) begin : gBadDataW
        $error("aes_iter_encrypt: DATA_W must be 128");
    end

    localparam int         NR         = numRounds(KEY_L);
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    aesState_e         stateQ, stateD;
    logic [DATA_W-1:0] blockQ, blockD;
    logic [DATA_W-1:0] ctQ, ctD;
    logic [KEY_L-1:0]  keyWinQ, keyWinD;
    logic [3:0]        roundQ, roundD;
    logic [127:0]      roundKey;
    logic [KEY_L-1:0]  nextWin;
    logic [127:0]      roundOut;
    logic              lastRound;
    logic              accept;

    function automatic logic [127:0] expandStep(input logic [127:0] prev, input logic [31:0] last,
                                                input logic rotate, input logic [7:0] rcon);
        logic [31:0] t, w0, w1, w2, w3;
        t  = rotate ? (subWord({last[23:0], last[31:24]}) ^ {rcon, 24'h0}) : subWord(last);
        w0 = prev[127:96] ^ t;
        w1 = prev[95:64]  ^ w0;
        w2 = prev[63:32]  ^ w1;
        w3 = prev[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // AES-128 derives round key r from key r-1 as it is needed; AES-256 keeps
    // keys r-1 and r in the window and uses the lower half directly.
    if (KEY_L == 128) begin : gKey128
        always_comb begin
            roundKey = expandStep(keyWinQ, keyWinQ[31:0], 1'b1, rconAt(roundQ - 4'd1));
            nextWin  = roundKey;
        end
    end else begin : gKey256
        always_comb begin
            roundKey = keyWinQ[127:0];
            nextWin  = {keyWinQ[127:0],
                        expandStep(keyWinQ[255:128], keyWinQ[31:0], roundQ[0],
                                   rconAt((roundQ - 4'd1) >> 1))};
        end
    end

    assign lastRound = (roundQ == LAST_ROUND);

    aes_round uRound (
        .state_i      (blockQ),
        .roundKey_i   (roundKey),
        .finalRound_i (lastRound),
        .state_o      (roundOut)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ  <= IDLE;
            blockQ  <= '0;
            ctQ     <= '0;
            keyWinQ <= '0;
            roundQ  <= '0;
        end else begin
            stateQ  <= stateD;
            blockQ  <= blockD;
            ctQ     <= ctD;
            keyWinQ <= keyWinD;
            roundQ  <= roundD;
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (in_valid) stateD = ROUND;
            ROUND:   if (lastRound) stateD = DONE;
            DONE:    if (out_ready) stateD = in_valid ? ROUND : IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (stateQ == IDLE) || ((stateQ == DONE) && out_ready);
        busy      = (stateQ == ROUND);
        out_valid = (stateQ == DONE);
    end

    assign accept      = in_valid && in_ready;
    assign cipher_text = ctQ;

    // Acceptance only happens in IDLE/DONE, so it never competes with a round step.
    always_comb begin
        blockD  = blockQ;
        ctD     = ctQ;
        keyWinD = keyWinQ;
        roundD  = roundQ;
        if (accept) begin
            blockD  = plain_text ^ cipher_key[KEY_L-1 -: 128];
            keyWinD = cipher_key;
            roundD  = 4'd1;
        end else if (stateQ == ROUND) begin
            blockD  = roundOut;
            keyWinD = nextWin;
            roundD  = roundQ + 4'd1;
            if (lastRound) ctD = roundOut;
        end
    end

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// Randomised bench for aes_iter_encrypt (AES-128 and AES-256 instances) against a
// byte-level AES model built from GF(2^8) arithmetic.
module tb_aes_iter_encrypt;

    logic         clk = 1'b0;
    logic         reset, outReady;
    logic         inValidA, inValidB;
    logic [127:0] keyA, ptA, ptB;
    logic [255:0] keyB;
    logic         inReadyA, inReadyB, outValidA, outValidB, busyA, busyB;
    logic [127:0] ctA, ctB;
    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sboxRef [256];

    always #5 clk = ~clk;

    aes_iter_encrypt #(.KEY_L(128), .DATA_W(128)) dutA (
        .clk(clk), .reset(reset), .in_valid(inValidA), .in_ready(inReadyA),
        .cipher_key(keyA), .plain_text(ptA), .out_valid(outValidA),
        .out_ready(outReady), .cipher_text(ctA), .busy(busyA)
    );

    aes_iter_encrypt #(.KEY_L(256), .DATA_W(128)) dutB (
        .clk(clk), .reset(reset), .in_valid(inValidB), .in_ready(inReadyB),
        .cipher_key(keyB), .plain_text(ptB), .out_valid(outValidB),
        .out_ready(outReady), .cipher_text(ctB), .busy(busyB)
    );

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    // S-box = affine transform of the multiplicative inverse in GF(2^8).
    task automatic buildSbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sboxRef[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subW(input logic [31:0] w);
        return {sboxRef[w[31:24]], sboxRef[w[23:16]], sboxRef[w[15:8]], sboxRef[w[7:0]]};
    endfunction

    // Key is left-aligned: a 128-bit key occupies bits [255:128].
    function automatic logic [127:0] aesRef(input logic [255:0] key, input int keyL, input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        int nk, nr;
        nk = keyL / 32;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subW({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subW(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sboxRef[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
            for (int c = 0; c < 4; c++) begin
                for (int k = 0; k < 4; k++) a[k] = t[4*c+k];
                for (int k = 0; k < 4; k++) begin
                    if (r < nr)
                        s[4*c+k] = gmul(a[k], 8'h02) ^ gmul(a[(k+1)%4], 8'h03) ^ a[(k+2)%4] ^ a[(k+3)%4];
                    else
                        s[4*c+k] = a[k];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic readyOf(input int sel);
        return (sel == 0) ? inReadyA : inReadyB;
    endfunction

    function automatic logic validOf(input int sel);
        return (sel == 0) ? outValidA : outValidB;
    endfunction

    function automatic logic [127:0] ctOf(input int sel);
        return (sel == 0) ? ctA : ctB;
    endfunction

    // Presents one request and returns just after its acceptance edge.
    task automatic applyStimulus(input int sel, input logic [255:0] key, input logic [127:0] pt, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!readyOf(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = readyOf(sel);
        if (!ok) begin
            checkOutput("readyTimeout", 256'd0, 256'd1);
        end else begin
            if (sel == 0) begin
                keyA = key[255:128]; ptA = pt; inValidA = 1'b1;
            end else begin
                keyB = key; ptB = pt; inValidB = 1'b1;
            end
            @(posedge clk);
            #1;
            inValidA = 1'b0;
            inValidB = 1'b0;
        end
    endtask

    // Counts edges after acceptance until out_valid is seen; -1 on timeout.
    task automatic waitResult(input int sel, output int lat);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (validOf(sel)) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) checkOutput("resultTimeout", 256'd0, 256'd1);
    endtask

    task automatic runTxn(input int sel, input logic [255:0] key, input logic [127:0] pt,
                          input logic [127:0] exp, input string tag);
        bit ok;
        int lat;
        applyStimulus(sel, key, pt, ok);
        if (ok) begin
            waitResult(sel, lat);
            if (lat >= 0) begin
                checkOutput(tag, 256'(ctOf(sel)), 256'(exp));
                checkOutput({tag, "Latency"}, 256'(lat), 256'((sel == 0) ? 10 : 14));
            end
        end
    endtask

    task automatic runRandom(input int sel, input string tag);
        logic [255:0] key;
        logic [127:0] pt;
        key = {rand128(), rand128()};
        if (sel == 0) key[127:0] = '0;
        pt = rand128();
        runTxn(sel, key, pt, aesRef(key, (sel == 0) ? 128 : 256, pt), tag);
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [255:0] key;
        logic [127:0] pt, exp, held;
        int pulses, lastCyc, cyc, badStable, badReady, lat;
        bit ok;

        reset = 1'b1; outReady = 1'b1;
        inValidA = 1'b0; inValidB = 1'b0;
        keyA = '0; keyB = '0; ptA = '0; ptB = '0;
        buildSbox();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("rstInReadyA", 256'(inReadyA), 256'd1);
        checkOutput("rstOutValidA", 256'(outValidA), 256'd0);
        checkOutput("rstBusyA", 256'(busyA), 256'd0);
        checkOutput("rstCtA", 256'(ctA), 256'd0);
        checkOutput("rstInReadyB", 256'(inReadyB), 256'd1);
        checkOutput("rstCtB", 256'(ctB), 256'd0);

        checkOutput("modelKat128", 256'(aesRef({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128,
                    128'h00112233445566778899aabbccddeeff)), 256'(128'h69c4e0d86a7b0430d8cdb78070b4c55a));

        // Known-answer vectors for both key sizes.
        runTxn(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 128'h00112233445566778899aabbccddeeff,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a, "kat128");
        runTxn(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
               128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, "kat256");

        // Back-to-back with in_valid and out_ready held high.
        @(negedge clk);
        keyA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ptA  = 128'h3243f6a8885a308d313198a2e0370734;
        inValidA = 1'b1;
        pulses = 0; lastCyc = -1; cyc = 0;
        for (int i = 0; i < 60 && pulses < 3; i++) begin
            @(negedge clk);
            cyc++;
            if (outValidA) begin
                pulses++;
                checkOutput("b2bCt", 256'(ctA), 256'(128'h3925841d02dc09fbdc118597196a0b32));
                if (lastCyc >= 0) checkOutput("b2bPeriod", 256'(cyc - lastCyc), 256'd11);
                lastCyc = cyc;
                if (pulses == 3) inValidA = 1'b0;
            end
        end
        inValidA = 1'b0;
        checkOutput("b2bCount", 256'(pulses), 256'd3);
        @(negedge clk);
        checkOutput("b2bIdleValid", 256'(outValidA), 256'd0);
        checkOutput("b2bIdleBusy", 256'(busyA), 256'd0);

        // Backpressure: result must hold while out_ready is low.
        outReady = 1'b0;
        runRandom(0, "bpCt");
        held = ctA; badStable = 0; badReady = 0;
        repeat (20) begin
            @(negedge clk);
            if (!outValidA || ctA !== held) badStable++;
            if (inReadyA) badReady++;
        end
        checkOutput("bpStable", 256'(badStable), 256'd0);
        checkOutput("bpInReady", 256'(badReady), 256'd0);
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("bpHandoff", 256'(outValidA), 256'd0);
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (outValidA) pulses++;
        end
        checkOutput("bpSingle", 256'(pulses), 256'd0);
        checkOutput("bpCtHeld", 256'(ctA), 256'(held));

        // Reset during round 5 of an AES-256 operation.
        key = {rand128(), rand128()};
        pt  = rand128();
        applyStimulus(1, key, pt, ok);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("midRstValid", 256'(outValidB), 256'd0);
        checkOutput("midRstCt", 256'(ctB), 256'd0);
        checkOutput("midRstInReady", 256'(inReadyB), 256'd1);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (outValidB) pulses++;
        end
        checkOutput("midRstNoResult", 256'(pulses), 256'd0);
        runRandom(1, "postRst");

        // Inputs wiggling during ROUND must not disturb the result.
        key = {rand128(), 128'h0};
        pt  = rand128();
        exp = aesRef(key, 128, pt);
        applyStimulus(0, key, pt, ok);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (outValidA) begin
                lat = i;
                break;
            end
            keyA = rand128();
            ptA  = rand128();
            inValidA = 1'($urandom_range(0, 1));
        end
        inValidA = 1'b0;
        checkOutput("toggleDone", 256'(lat >= 0), 256'd1);
        checkOutput("toggleCt", 256'(ctA), 256'(exp));

        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            runRandom(n % 2, (n % 2 == 0) ? "rand128" : "rand256");
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_iter_encrypt.md
AES_ITER_ENCRYPT -- requirements
Module: aes_iter_encrypt

Interface
REQ-001 SHALL have parameter KEY_L, default 128; cipher key width, legal values 128 or 256; any other value is a elaboration-time error.
REQ-002 SHALL have parameter DATA_W, default 128; block width, fixed at 128; any other value is an elaboration-time error.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  plain_text/cipher_key are valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a new request this cycle.
REQ-007 SHALL have port cipher_key  input  KEY_L  cipher key, byte 0 in the MSBs (FIPS-197 order).
REQ-008 SHALL have port plain_text  input  DATA_W  plaintext block, byte 0 in the MSBs.
REQ-009 SHALL have port out_valid  output  1  cipher_text holds a completed result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port cipher_text  output  DATA_W  ciphertext, byte 0 in the MSBs.
REQ-012 SHALL have port busy  output  1  high in ROUND state.

Function
REQ-013 SHALL implement FIPS-197 AES encryption iteratively, one round per clock; NR = 10 for KEY_L=128, NR = 14 for KEY_L=256.
REQ-014 SHALL have FSM states IDLE, ROUND and DONE.
REQ-015 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-016 SHALL, on acceptance (in_valid and in_ready at edge T), load state = plain_text XOR round key 0, load the key schedule register from cipher_key, set round counter to 1 and enter ROUND.
REQ-017 SHALL, in ROUND, apply SubBytes, ShiftRows, MixColumns and AddRoundKey for round r, 1 <= r < NR; round NR omits MixColumns.
REQ-018 SHALL, after round NR at edge T+NR, enter DONE with out_valid=1 and cipher_text=result; latency is NR cycles from the acceptance edge to out_valid.
REQ-019 SHALL, in DONE with out_ready=0, hold cipher_text and out_valid stable indefinitely.
REQ-020 SHALL, in DONE with out_ready=1 and in_valid=0, return to IDLE and deassert out_valid on the next edge.
REQ-021 SHALL, in DONE with out_ready=1 and in_valid=1, complete the handoff and accept the new request on the same edge, entering ROUND; a request is never dropped or duplicated.
REQ-022 SHALL ignore in_valid, plain_text and cipher_key while in ROUND; inputs are sampled only on the acceptance edge.
REQ-023 SHALL hold cipher_text at its last result when out_valid=0; cipher_text changes only on entry to DONE.
REQ-024 SHALL generate round keys on the fly, one per cycle, from a KEY_L-bit window register; no precomputed 11- or 15-entry key table.
REQ-025 SHALL, for KEY_L=256, use cipher_key[255:128] as round key 0 and cipher_key[127:0] as round key 1; later round keys alternate RotWord+SubWord+Rcon and SubWord-only expansion steps per FIPS-197.
REQ-026 SHALL step Rcon through 01,02,04,08,10,20,40,80,1B,36.

Reset
REQ-027 SHALL, when reset=1 at a clk edge, set state=IDLE, out_valid=0, busy=0, cipher_text=0, round counter=0 and key window=0; in_ready=1 in the following cycle.
REQ-028 SHALL abort any in-flight operation on reset mid-ROUND or mid-DONE with no result emitted; the first post-reset request behaves as from cold.
REQ-029 SHALL give reset priority over every handshake on the same edge.

Structure
REQ-030 SHALL place the S-box table, Rcon constants, the FSM state enum and NR derivation in shared package aes_pkg.
REQ-031 SHALL instantiate a single combinational sub-module aes_round (inputs: state, round key, final-round flag; output: next state); key expansion stays in aes_iter_encrypt.

Verification
REQ-032 SHALL verify the KEY_L=128 vector: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after the acceptance edge.
REQ-033 SHALL verify the KEY_L=256 vector: key 000102...1e1f, same pt -> ct 8ea2b7ca516745bfeafc49904b496089, with latency 14.
REQ-034 SHALL verify back-to-back operation: out_ready=1 and in_valid=1 held, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32 repeated, one result every 11 cycles, no IDLE gap.
REQ-035 SHALL verify backpressure: out_ready=0 for 20 cycles after DONE -> cipher_text and out_valid stable, in_ready=0; then out_ready=1 -> one handoff only.
REQ-036 SHALL verify reset asserted at round 5 -> out_valid stays 0, cipher_text=0, in_ready=1 next cycle; the next request yields the correct ct.
REQ-037 SHALL verify that input changes during ROUND have no effect on the result: plain_text and cipher_key toggled every cycle -> ct matches the values sampled on the acceptance edge.
